// File: rtl/gpu_mem_pkg.sv
// Shared types and helpers for the memory channel arbiter.
package gpu_mem_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReadWaiting,
    StWriteWaiting,
    StReadRelaying,
    StWriteRelaying
  } channel_state_e;

  // Index width for n requesters; never narrower than one bit.
  function automatic int unsigned idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Explicit modulo so non-power-of-two consumer counts wrap correctly.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1) % n;
  endfunction

  localparam int unsigned CONSUMER_IDX_BITS = idx_bits(4);

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr not in exclude.
module rr_picker #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned IDX_BITS = 2
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [NUM_REQ-1:0]  exclude,
  input  logic [IDX_BITS-1:0] ptr,
  output logic                grant_valid,
  output logic [IDX_BITS-1:0] grant_idx
);

  always_comb begin
    int unsigned j;
    j           = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = (32'(ptr) + k) % NUM_REQ;
      if (!grant_valid && req[j] && !exclude[j]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_BITS'(j);
      end
    end
  end

endmodule

// File: rtl/mem_channel_arbiter.sv
// Shares NUM_CHANNELS memory channels among NUM_CONSUMERS requesters, round-robin,
// with one FSM per channel and registered outputs.
module mem_channel_arbiter
  import gpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_BITS     = 8,
  parameter int unsigned DATA_BITS     = 16,
  parameter int unsigned NUM_CONSUMERS = 4,
  parameter int unsigned NUM_CHANNELS  = 1,
  parameter int unsigned WRITE_ENABLE  = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CONSUMERS-1:0]          consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]          consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]          consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]          consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]           mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_read_address,
  input  logic [NUM_CHANNELS-1:0]           mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0] mem_read_data,
  output logic [NUM_CHANNELS-1:0]           mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_write_address,
  output logic [NUM_CHANNELS*DATA_BITS-1:0] mem_write_data,
  input  logic [NUM_CHANNELS-1:0]           mem_write_ready
);

  localparam int unsigned IdxBits = idx_bits(NUM_CONSUMERS);
  localparam bit          WrEn    = (WRITE_ENABLE != 0);

  channel_state_e                     state_q [NUM_CHANNELS];
  channel_state_e                     state_d [NUM_CHANNELS];
  logic [IdxBits-1:0]                 cons_q  [NUM_CHANNELS];
  logic [IdxBits-1:0]                 cons_d  [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0]           claim_q, claim_d;
  logic [IdxBits-1:0]                 rr_q, rr_d;
  logic [NUM_CONSUMERS-1:0]           req;
  logic [NUM_CHANNELS-1:0]            chan_take;
  logic [IdxBits-1:0]                 chan_idx [NUM_CHANNELS];

  logic [NUM_CHANNELS-1:0]            mrv_q, mrv_d, mwv_q, mwv_d;
  logic [NUM_CHANNELS*ADDR_BITS-1:0]  mra_q, mra_d, mwa_q, mwa_d;
  logic [NUM_CHANNELS*DATA_BITS-1:0]  mwd_q, mwd_d;
  logic [NUM_CONSUMERS-1:0]           crr_q, crr_d, cwr_q, cwr_d;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] crd_q, crd_d;

  assign req = consumer_read_valid | (WrEn ? consumer_write_valid : '0);

  // Channels resolve in index order: each sees the claims plus grants of lower channels.
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    logic [NUM_CONSUMERS-1:0] excl_in, excl_out;
    logic [IdxBits-1:0]       ptr_in, ptr_out, pick_idx;
    logic                     pick_valid, take;

    if (c == 0) begin : g_first
      assign excl_in = claim_q;
      assign ptr_in  = rr_q;
    end else begin : g_next
      assign excl_in = g_ch[c-1].excl_out;
      assign ptr_in  = g_ch[c-1].ptr_out;
    end

    rr_picker #(
      .NUM_REQ (NUM_CONSUMERS),
      .IDX_BITS(IdxBits)
    ) u_picker (
      .req        (req),
      .exclude    (excl_in),
      .ptr        (ptr_in),
      .grant_valid(pick_valid),
      .grant_idx  (pick_idx)
    );

    assign take     = (state_q[c] == StIdle) && pick_valid;
    assign excl_out = excl_in | (take ? (NUM_CONSUMERS'(1) << pick_idx) : '0);
    assign ptr_out  = take ? IdxBits'(wrap_inc(32'(pick_idx), NUM_CONSUMERS)) : ptr_in;
    assign chan_take[c] = take;
    assign chan_idx[c]  = pick_idx;
  end

  assign rr_d = g_ch[NUM_CHANNELS-1].ptr_out;

  always_comb begin
    int unsigned ci;
    ci      = 0;
    state_d = state_q;
    cons_d  = cons_q;
    claim_d = claim_q;
    mrv_d   = mrv_q;
    mra_d   = mra_q;
    mwv_d   = mwv_q;
    mwa_d   = mwa_q;
    mwd_d   = mwd_q;
    crr_d   = crr_q;
    cwr_d   = cwr_q;
    crd_d   = crd_q;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      ci = 32'(cons_q[c]);
      unique case (state_q[c])
        StIdle: begin
          if (chan_take[c]) begin
            ci          = 32'(chan_idx[c]);
            claim_d[ci] = 1'b1;
            cons_d[c]   = chan_idx[c];
            if (consumer_read_valid[ci]) begin
              mrv_d[c] = 1'b1;
              mra_d[c*ADDR_BITS +: ADDR_BITS] = consumer_read_address[ci*ADDR_BITS +: ADDR_BITS];
              state_d[c] = StReadWaiting;
            end else begin
              mwv_d[c] = 1'b1;
              mwa_d[c*ADDR_BITS +: ADDR_BITS] = consumer_write_address[ci*ADDR_BITS +: ADDR_BITS];
              mwd_d[c*DATA_BITS +: DATA_BITS] = consumer_write_data[ci*DATA_BITS +: DATA_BITS];
              state_d[c] = StWriteWaiting;
            end
          end
        end
        StReadWaiting: begin
          if (mem_read_ready[c]) begin
            mrv_d[c]  = 1'b0;
            crr_d[ci] = 1'b1;
            crd_d[ci*DATA_BITS +: DATA_BITS] = mem_read_data[c*DATA_BITS +: DATA_BITS];
            state_d[c] = StReadRelaying;
          end
        end
        StWriteWaiting: begin
          if (mem_write_ready[c]) begin
            mwv_d[c]   = 1'b0;
            cwr_d[ci]  = 1'b1;
            state_d[c] = StWriteRelaying;
          end
        end
        StReadRelaying: begin
          if (!consumer_read_valid[ci]) begin
            crr_d[ci]   = 1'b0;
            claim_d[ci] = 1'b0;
            state_d[c]  = StIdle;
          end
        end
        StWriteRelaying: begin
          if (!consumer_write_valid[ci]) begin
            cwr_d[ci]   = 1'b0;
            claim_d[ci] = 1'b0;
            state_d[c]  = StIdle;
          end
        end
        default: state_d[c] = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c] <= StIdle;
        cons_q[c]  <= '0;
      end
      claim_q <= '0;
      rr_q    <= '0;
      mrv_q   <= '0;
      mra_q   <= '0;
      mwv_q   <= '0;
      mwa_q   <= '0;
      mwd_q   <= '0;
      crr_q   <= '0;
      cwr_q   <= '0;
      crd_q   <= '0;
    end else begin
      state_q <= state_d;
      cons_q  <= cons_d;
      claim_q <= claim_d;
      rr_q    <= rr_d;
      mrv_q   <= mrv_d;
      mra_q   <= mra_d;
      mwv_q   <= mwv_d;
      mwa_q   <= mwa_d;
      mwd_q   <= mwd_d;
      crr_q   <= crr_d;
      cwr_q   <= cwr_d;
      crd_q   <= crd_d;
    end
  end

  assign mem_read_valid      = mrv_q;
  assign mem_read_address    = mra_q;
  assign consumer_read_ready = crr_q;
  assign consumer_read_data  = crd_q;

  if (WrEn) begin : g_wr
    assign mem_write_valid      = mwv_q;
    assign mem_write_address    = mwa_q;
    assign mem_write_data       = mwd_q;
    assign consumer_write_ready = cwr_q;
  end else begin : g_no_wr
    assign mem_write_valid      = '0;
    assign mem_write_address    = '0;
    assign mem_write_data       = '0;
    assign consumer_write_ready = '0;
  end

endmodule

// File: tb/tb_mem_channel_arbiter.sv
// Directed bench: a 2-channel read/write arbiter and a 1-channel read-only arbiter,
// each behind a small memory model that answers two cycles after a request.
module tb_mem_channel_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Instance A: data memory, 2 channels, writes enabled
  logic        a_reset;
  logic [3:0]  a_rv, a_rr, a_wv, a_wr;
  logic [31:0] a_ra, a_wa;
  logic [63:0] a_rd, a_wd;
  logic [1:0]  a_mrv, a_mrr, a_mwv, a_mwr;
  logic [15:0] a_mra, a_mwa;
  logic [31:0] a_mrd, a_mwd;

  // Instance B: program memory, 1 channel, read-only
  logic        b_reset;
  logic [3:0]  b_rv, b_rr, b_wv, b_wr;
  logic [31:0] b_ra, b_wa;
  logic [63:0] b_rd, b_wd;
  logic [0:0]  b_mrv, b_mrr, b_mwv, b_mwr;
  logic [7:0]  b_mra, b_mwa;
  logic [15:0] b_mrd, b_mwd;

  assign b_mwr = '0;

  mem_channel_arbiter #(
    .ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(4), .NUM_CHANNELS(2), .WRITE_ENABLE(1)
  ) u_dut_a (
    .clk(clk), .reset(a_reset),
    .consumer_read_valid(a_rv), .consumer_read_address(a_ra),
    .consumer_read_ready(a_rr), .consumer_read_data(a_rd),
    .consumer_write_valid(a_wv), .consumer_write_address(a_wa),
    .consumer_write_data(a_wd), .consumer_write_ready(a_wr),
    .mem_read_valid(a_mrv), .mem_read_address(a_mra),
    .mem_read_ready(a_mrr), .mem_read_data(a_mrd),
    .mem_write_valid(a_mwv), .mem_write_address(a_mwa),
    .mem_write_data(a_mwd), .mem_write_ready(a_mwr)
  );

  mem_channel_arbiter #(
    .ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(4), .NUM_CHANNELS(1), .WRITE_ENABLE(0)
  ) u_dut_b (
    .clk(clk), .reset(b_reset),
    .consumer_read_valid(b_rv), .consumer_read_address(b_ra),
    .consumer_read_ready(b_rr), .consumer_read_data(b_rd),
    .consumer_write_valid(b_wv), .consumer_write_address(b_wa),
    .consumer_write_data(b_wd), .consumer_write_ready(b_wr),
    .mem_read_valid(b_mrv), .mem_read_address(b_mra),
    .mem_read_ready(b_mrr), .mem_read_data(b_mrd),
    .mem_write_valid(b_mwv), .mem_write_address(b_mwa),
    .mem_write_data(b_mwd), .mem_write_ready(b_mwr)
  );

  // Unwritten memory holds addr*8+2, so 0x05 reads back as 0x2A.
  function automatic logic [15:0] pat(input logic [7:0] a);
    return {5'b0, a, 3'b0} + 16'd2;
  endfunction

  logic [15:0] a_wmem  [256];
  logic        a_wflag [256];
  int          a_rcnt  [2];
  int          a_wcnt  [2];
  int          b_rcnt;

  function automatic logic [15:0] a_mem_rd(input logic [7:0] a);
    return (a_wflag[a] === 1'b1) ? a_wmem[a] : pat(a);
  endfunction

  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (!a_reset) begin
        a_mrr[c]  <= 1'b0;
        a_mwr[c]  <= 1'b0;
        a_rcnt[c] <= 0;
        a_wcnt[c] <= 0;
      end else begin
        if (a_mrr[c]) begin
          a_mrr[c]  <= 1'b0;
          a_rcnt[c] <= 0;
        end else if (a_mrv[c]) begin
          if (a_rcnt[c] == 1) begin
            a_mrr[c] <= 1'b1;
            a_mrd[c*16 +: 16] <= a_mem_rd(a_mra[c*8 +: 8]);
          end else a_rcnt[c] <= a_rcnt[c] + 1;
        end
        if (a_mwr[c]) begin
          a_mwr[c]  <= 1'b0;
          a_wcnt[c] <= 0;
        end else if (a_mwv[c]) begin
          if (a_wcnt[c] == 1) begin
            a_mwr[c] <= 1'b1;
            a_wmem[a_mwa[c*8 +: 8]]  <= a_mwd[c*16 +: 16];
            a_wflag[a_mwa[c*8 +: 8]] <= 1'b1;
          end else a_wcnt[c] <= a_wcnt[c] + 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (!b_reset) begin
      b_mrr  <= '0;
      b_rcnt <= 0;
    end else if (b_mrr[0]) begin
      b_mrr  <= '0;
      b_rcnt <= 0;
    end else if (b_mrv[0]) begin
      if (b_rcnt == 1) begin
        b_mrr <= 1'b1;
        b_mrd <= pat(b_mra);
      end else b_rcnt <= b_rcnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic reset_a();
    @(negedge clk);
    a_reset = 1'b0;
    repeat (2) @(negedge clk);
    a_reset = 1'b1;
  endtask

  // One transaction on instance A; returns read data and any observed memory write.
  task automatic do_txn(input int cons, input bit wr, input logic [7:0] addr,
                        input logic [15:0] wdata, output logic [15:0] rdata, output bit ok,
                        output logic [7:0] maddr, output logic [15:0] mdata);
    ok = 1'b0; rdata = '0; maddr = '0; mdata = '0;
    @(negedge clk);
    if (wr) begin
      a_wv[cons] = 1'b1; a_wa[cons*8 +: 8] = addr; a_wd[cons*16 +: 16] = wdata;
    end else begin
      a_rv[cons] = 1'b1; a_ra[cons*8 +: 8] = addr;
    end
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      for (int ch = 0; ch < 2; ch++) begin
        if (a_mwv[ch]) begin
          maddr = a_mwa[ch*8 +: 8];
          mdata = a_mwd[ch*16 +: 16];
        end
      end
      if (wr ? a_wr[cons] : a_rr[cons]) begin
        ok = 1'b1;
        rdata = a_rd[cons*16 +: 16];
      end
    end
    a_rv[cons] = 1'b0;
    a_wv[cons] = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    int          cons;
    bit          wr;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [15:0] rdata, x, y, mdata;
    logic [7:0]  maddr;
    bit          ok;
    int          cg [2][2];
    int          ccnt [2];
    int          served [4];
    int          dbl, extra, rd_bad, wr_seen, nserv, gcount;
    int          glog [4];
    logic [1:0]  prev2;
    logic        prev1;

    vecs[0] = '{0, 1'b0, 8'h05, 16'h0000, 16'h002A};
    vecs[1] = '{3, 1'b1, 8'h10, 16'h000B, 16'h0000};
    vecs[2] = '{1, 1'b0, 8'h10, 16'h0000, 16'h000B};
    vecs[3] = '{2, 1'b0, 8'hFF, 16'h0000, 16'h07FA};
    vecs[4] = '{1, 1'b1, 8'h20, 16'hBEEF, 16'h0000};
    vecs[5] = '{0, 1'b0, 8'h20, 16'h0000, 16'hBEEF};
    vecs[6] = '{3, 1'b0, 8'h00, 16'h0000, 16'h0002};

    a_reset = 1'b0; b_reset = 1'b0;
    a_rv = '0; a_wv = '0; a_ra = '0; a_wa = '0; a_wd = '0;
    b_rv = '0; b_wv = '0; b_ra = '0; b_wa = '0; b_wd = '0;
    repeat (3) @(negedge clk);
    check("rst_a_mem_read_valid", 32'(a_mrv), 0);
    check("rst_a_mem_write_valid", 32'(a_mwv), 0);
    check("rst_a_cons_read_ready", 32'(a_rr), 0);
    check("rst_a_cons_write_ready", 32'(a_wr), 0);
    check("rst_a_cons_read_data", a_rd[31:0] | a_rd[63:32], 0);
    check("rst_b_mem_read_valid", 32'(b_mrv), 0);
    a_reset = 1'b1; b_reset = 1'b1;

    // Single read with cycle-exact latency
    @(negedge clk);
    a_rv[0] = 1'b1; a_ra[7:0] = 8'h05;
    @(negedge clk);
    check("single_mem_valid", 32'(a_mrv), 32'b01);
    check("single_mem_addr", 32'(a_mra[7:0]), 32'h05);
    @(negedge clk);
    @(negedge clk);
    check("single_mem_ready", 32'(a_mrr[0]), 1);
    check("single_no_early_ready", 32'(a_rr[0]), 0);
    @(negedge clk);
    check("single_ready", 32'(a_rr[0]), 1);
    check("single_data", 32'(a_rd[15:0]), 32'h2A);
    check("single_mem_valid_dropped", 32'(a_mrv[0]), 0);
    @(negedge clk);
    check("single_ready_held", 32'(a_rr[0]), 1);
    check("single_data_held", 32'(a_rd[15:0]), 32'h2A);
    a_rv[0] = 1'b0;
    @(negedge clk);
    check("single_ready_release", 32'(a_rr[0]), 0);

    for (int i = 0; i < 7; i++) begin
      do_txn(vecs[i].cons, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rdata, ok, maddr, mdata);
      check($sformatf("vec%0d_done", i), 32'(ok), 1);
      if (vecs[i].wr) begin
        check($sformatf("vec%0d_wr_addr", i), 32'(maddr), 32'(vecs[i].addr));
        check($sformatf("vec%0d_wr_data", i), 32'(mdata), 32'(vecs[i].wdata));
        check($sformatf("vec%0d_mem", i), 32'(a_wmem[vecs[i].addr]), 32'(vecs[i].wdata));
      end else begin
        check($sformatf("vec%0d_rd_data", i), 32'(rdata), 32'(vecs[i].exp));
      end
    end

    // Contention: four readers on two channels from a fresh round-robin pointer
    reset_a();
    for (int c = 0; c < 2; c++) begin
      ccnt[c] = 0; cg[c][0] = -1; cg[c][1] = -1;
    end
    for (int i = 0; i < 4; i++) served[i] = 0;
    dbl = 0; extra = 0; rd_bad = 0; prev2 = '0;
    @(negedge clk);
    a_rv = 4'hF;
    a_ra = {8'd3, 8'd2, 8'd1, 8'd0};
    for (int n = 0; n < 60 && (a_rv != 0 || a_rr != 0); n++) begin
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        if (a_mrv[c] && !prev2[c] && ccnt[c] < 2) begin
          cg[c][ccnt[c]] = int'(a_mra[c*8 +: 8]);
          ccnt[c]++;
        end
      end
      prev2 = a_mrv;
      if (a_mrv == 2'b11 && a_mra[7:0] == a_mra[15:8]) dbl++;
      for (int i = 0; i < 4; i++) begin
        if (a_rr[i] && !a_rv[i]) extra++;
        else if (a_rr[i] && a_rv[i]) begin
          served[i]++;
          if (a_rd[i*16 +: 16] !== pat(8'(i))) rd_bad++;
          a_rv[i] = 1'b0;
        end
      end
    end
    check("cont_ch0_first", 32'(cg[0][0]), 0);
    check("cont_ch1_first", 32'(cg[1][0]), 1);
    check("cont_ch0_second", 32'(cg[0][1]), 2);
    check("cont_ch1_second", 32'(cg[1][1]), 3);
    for (int i = 0; i < 4; i++) check($sformatf("cont_served%0d", i), 32'(served[i]), 1);
    check("cont_double_grant", 32'(dbl), 0);
    check("cont_extra_ready", 32'(extra), 0);
    check("cont_read_data", 32'(rd_bad), 0);

    // Reset while a channel sits in READ_WAITING
    @(negedge clk);
    a_rv[1] = 1'b1; a_ra[15:8] = 8'h07;
    @(negedge clk);
    check("mid_rst_pre_valid", 32'(a_mrv[0]), 1);
    a_reset = 1'b0;
    @(negedge clk);
    a_rv[1] = 1'b0;
    check("mid_rst_mem_read_valid", 32'(a_mrv), 0);
    check("mid_rst_mem_read_addr", 32'(a_mra), 0);
    check("mid_rst_cons_ready", 32'(a_rr), 0);
    check("mid_rst_cons_data", a_rd[31:0] | a_rd[63:32], 0);
    check("mid_rst_write_side", 32'(a_mwv) | 32'(a_wr) | 32'(a_mwa) | a_mwd, 0);
    @(negedge clk);
    a_reset = 1'b1;
    nserv = 0;
    repeat (6) begin
      @(negedge clk);
      if (a_rr != 0 || a_mrv != 0) nserv++;
    end
    check("mid_rst_no_late_response", 32'(nserv), 0);
    do_txn(1, 1'b0, 8'h07, 16'h0, rdata, ok, maddr, mdata);
    check("post_rst_read", 32'(rdata), 32'(pat(8'h07)));

    // Matrix-add style kernel: C[16+i] = A[i] + B[i+8]
    for (int i = 0; i < 8; i++) begin
      do_txn(i % 4, 1'b0, 8'(i), 16'h0, x, ok, maddr, mdata);
      do_txn(i % 4, 1'b0, 8'(i + 8), 16'h0, y, ok, maddr, mdata);
      do_txn((i + 1) % 4, 1'b1, 8'(16 + i), x + y, rdata, ok, maddr, mdata);
    end
    for (int i = 0; i < 8; i++) begin
      do_txn(3 - (i % 4), 1'b0, 8'(16 + i), 16'h0, rdata, ok, maddr, mdata);
      check($sformatf("kernel_c%0d", 16 + i), 32'(rdata), 32'(pat(8'(i)) + pat(8'(i + 8))));
    end

    // Read-only instance: fairness on one channel while a write request is ignored
    @(negedge clk);
    b_wv = 4'b0100; b_wa[23:16] = 8'h30; b_wd[47:32] = 16'h1234;
    b_rv[1:0] = 2'b11; b_ra[7:0] = 8'd0; b_ra[15:8] = 8'd1;
    gcount = 0; nserv = 0; rd_bad = 0; wr_seen = 0; prev1 = 1'b0;
    for (int i = 0; i < 4; i++) glog[i] = -1;
    for (int n = 0; n < 120 && nserv < 4; n++) begin
      @(negedge clk);
      if (b_mwv != 0 || b_wr != 0) wr_seen++;
      if (b_mrv[0] && !prev1 && gcount < 4) begin
        glog[gcount] = int'(b_mra);
        gcount++;
      end
      prev1 = b_mrv[0];
      for (int i = 0; i < 2; i++) begin
        if (b_rv[i] && b_rr[i]) begin
          nserv++;
          if (b_rd[i*16 +: 16] !== pat(8'(i))) rd_bad++;
          b_rv[i] = 1'b0;
        end else if (!b_rv[i]) b_rv[i] = 1'b1;
      end
    end
    b_rv = '0;
    repeat (6) begin
      @(negedge clk);
      if (b_mwv != 0 || b_wr != 0) wr_seen++;
    end
    b_wv = '0;
    for (int i = 0; i < 4; i++) check($sformatf("fair_grant%0d", i), 32'(glog[i]), 32'(i % 2));
    check("fair_served", 32'(nserv), 4);
    check("fair_read_data", 32'(rd_bad), 0);
    check("ro_no_write", 32'(wr_seen), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

endmodule
